// File: rtl/ysyx_23060203_idu_if.sv
// Decode-stage bus: fetch handshake in, execute handshake out, writeback notify.
`timescale 1ns/1ps
interface ysyx_23060203_idu_if;
  // fetch side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  // execute side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [3:0]  out_opc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_imm;
  logic        out_illegal;
  // writeback side
  logic        wb_valid;
  logic [4:0]  wb_rd;

  // decode stage view
  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready, wb_valid, wb_rd,
    output in_ready, out_valid, out_pc, out_inst, out_opc, out_rs1, out_rs2,
           out_rd, out_rd_wen, out_imm, out_illegal
  );

  // surrounding pipeline view
  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready, wb_valid, wb_rd,
    input  in_ready, out_valid, out_pc, out_inst, out_opc, out_rs1, out_rs2,
           out_rd, out_rd_wen, out_imm, out_illegal
  );
endinterface

// File: rtl/ysyx_23060203_idu.sv
// Instruction decode stage: one-entry holding register, combinational decode,
// per-register busy scoreboard with same-cycle writeback bypass.
`timescale 1ns/1ps
module ysyx_23060203_idu #(
  parameter int          NR_REG   = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                   clock,
  input logic                   reset,
  ysyx_23060203_idu_if.slave    bus
);

  typedef enum logic [3:0] {
    OPC_LUI     = 4'd0,
    OPC_AUIPC   = 4'd1,
    OPC_JAL     = 4'd2,
    OPC_JALR    = 4'd3,
    OPC_BRANCH  = 4'd4,
    OPC_LOAD    = 4'd5,
    OPC_STORE   = 4'd6,
    OPC_OPIMM   = 4'd7,
    OPC_OP      = 4'd8,
    OPC_FENCE   = 4'd9,
    OPC_SYSTEM  = 4'd10,
    OPC_ILLEGAL = 4'd15
  } opc_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // Registers 1..NR_REG-1 are tracked; x0 and anything beyond NR_REG never go busy.
  localparam logic [31:0] REG_MASK = (NR_REG >= 32) ? 32'hFFFF_FFFE
                                   : (((32'd1 << NR_REG) - 32'd1) & ~32'd1);

  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic [31:0] busy;

  opc_e        opc;
  imm_fmt_e    imm_fmt;
  logic        rs1_used, rs2_used, rd_write;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_wen;
  logic [31:0] busy_eff, busy_set, busy_clr;
  logic        hazard, out_valid, fire, in_ready, capture;

  // Classify the held word and pick its operand/immediate format.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held (no latch).
    opc      = OPC_ILLEGAL;
    imm_fmt  = IMM_NONE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_write = 1'b0;
    if (hold_inst[1:0] == 2'b11) begin
      unique case (hold_inst[6:2])
        5'b01101: begin opc = OPC_LUI;    imm_fmt = IMM_U; rd_write = 1'b1; end
        5'b00101: begin opc = OPC_AUIPC;  imm_fmt = IMM_U; rd_write = 1'b1; end
        5'b11011: begin opc = OPC_JAL;    imm_fmt = IMM_J; rd_write = 1'b1; end
        5'b11001: begin opc = OPC_JALR;   imm_fmt = IMM_I; rd_write = 1'b1; rs1_used = 1'b1; end
        5'b11000: begin opc = OPC_BRANCH; imm_fmt = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1; end
        5'b00000: begin opc = OPC_LOAD;   imm_fmt = IMM_I; rd_write = 1'b1; rs1_used = 1'b1; end
        5'b01000: begin opc = OPC_STORE;  imm_fmt = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1; end
        5'b00100: begin opc = OPC_OPIMM;  imm_fmt = IMM_I; rd_write = 1'b1; rs1_used = 1'b1; end
        5'b01100: begin opc = OPC_OP;     rd_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
        5'b00011: begin opc = OPC_FENCE; end
        5'b11100: begin
          opc      = OPC_SYSTEM;
          imm_fmt  = IMM_I;
          // CSR ops write rd; register-source forms have funct3[2] clear
          rd_write = (hold_inst[14:12] != 3'b000);
          rs1_used = ~hold_inst[14];
        end
        default: ;
      endcase
    end
  end

  // Sign-extended immediate assembly for the selected format.
  always_comb begin
    imm = 32'd0;
    unique case (imm_fmt)
      IMM_I: imm = {{20{hold_inst[31]}}, hold_inst[31:20]};
      IMM_S: imm = {{20{hold_inst[31]}}, hold_inst[31:25], hold_inst[11:7]};
      IMM_B: imm = {{19{hold_inst[31]}}, hold_inst[31], hold_inst[7],
                    hold_inst[30:25], hold_inst[11:8], 1'b0};
      IMM_U: imm = {hold_inst[31:12], 12'd0};
      IMM_J: imm = {{11{hold_inst[31]}}, hold_inst[31], hold_inst[19:12],
                    hold_inst[20], hold_inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  // Unused operand slots read as x0, which is never busy, so the hazard
  // check needs no separate "used" qualifiers.
  assign rs1    = rs1_used ? hold_inst[19:15] : 5'd0;
  assign rs2    = rs2_used ? hold_inst[24:20] : 5'd0;
  assign rd     = rd_write ? hold_inst[11:7]  : 5'd0;
  assign rd_wen = rd_write & (rd != 5'd0);

  assign busy_clr = bus.wb_valid ? (32'd1 << bus.wb_rd) : 32'd0;
  assign busy_eff = busy & ~busy_clr;
  assign hazard   = busy_eff[rs1] | busy_eff[rs2] | busy_eff[rd];

  assign out_valid = hold_valid & ~hazard & ~bus.flush;
  assign fire      = out_valid & bus.out_ready;
  assign in_ready  = ~hold_valid | fire;
  assign capture   = bus.in_valid & in_ready & ~bus.flush;
  assign busy_set  = (fire & rd_wen) ? (32'd1 << rd) : 32'd0;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = hold_pc;
  assign bus.out_inst    = hold_inst;
  assign bus.out_opc     = opc;
  assign bus.out_rs1     = rs1;
  assign bus.out_rs2     = rs2;
  assign bus.out_rd      = rd;
  assign bus.out_rd_wen  = rd_wen;
  assign bus.out_imm     = imm;
  assign bus.out_illegal = (opc == OPC_ILLEGAL);

  // Holding register: flush drops it, capture refills it, issue empties it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_pc    <= RESET_PC;
      hold_inst  <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (bus.flush)      hold_valid <= 1'b0;
      else if (capture)   hold_valid <= 1'b1;
      else if (fire)      hold_valid <= 1'b0;
      if (capture) begin
        hold_pc   <= bus.in_pc;
        hold_inst <= bus.in_inst;
      end
    end
  end

  // Busy scoreboard: issue marks rd, writeback releases it; set wins on overlap.
  // Flush leaves it alone since already-issued instructions still retire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the scoreboard is a plain flop vector and must be reset; a stale busy bit deadlocks issue.
      busy <= 32'd0;
    end else begin
      busy <= ((busy & ~busy_clr) | busy_set) & REG_MASK;
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_idu.sv
// Self-checking bench for the decode stage: scoreboard of expected issues
// plus directed checks of stall, flush, backpressure and async reset.
`timescale 1ns/1ps
module tb_ysyx_23060203_idu;

  localparam logic [31:0] TB_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  ysyx_23060203_idu_if bus ();

  ysyx_23060203_idu #(.NR_REG(32), .RESET_PC(TB_RESET_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [31:0] pc, logic [31:0] inst, logic [3:0] opc,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic wen, logic [31:0] imm, logic ill);
    exp_t e;
    e.pc = pc; e.inst = inst; e.opc = opc; e.rs1 = rs1; e.rs2 = rs2;
    e.rd = rd; e.wen = wen; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one fetch beat; it is captured on the next rising edge.
  task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
    #1;
    check("in_ready_on_offer", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic send(input exp_t e);
    sb.push_back(e);
    drive(e.pc, e.inst);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = r;
    step();
    bus.wb_valid = 1'b0;
  endtask

  // Scoreboard: every accepted issue is compared with the oldest expectation.
  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_issue_pc", bus.out_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue_pc",   bus.out_pc,             e.pc);
        check("issue_inst", bus.out_inst,           e.inst);
        check("issue_opc",  32'(bus.out_opc),       32'(e.opc));
        check("issue_rs1",  32'(bus.out_rs1),       32'(e.rs1));
        check("issue_rs2",  32'(bus.out_rs2),       32'(e.rs2));
        check("issue_rd",   32'(bus.out_rd),        32'(e.rd));
        check("issue_wen",  32'(bus.out_rd_wen),    32'(e.wen));
        check("issue_imm",  bus.out_imm,            e.imm);
        check("issue_ill",  32'(bus.out_illegal),   32'(e.ill));
      end
    end
  end

  exp_t        b2b[3];
  exp_t        mix[6];
  logic [31:0] b2b_busy[3];

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 32'd0;
    bus.in_inst   = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;

    // reset state
    @(negedge clock);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc",    bus.out_pc,         TB_RESET_PC);
    check("rst_out_inst",  bus.out_inst,       32'd0);
    check("rst_busy",      dut.busy,           32'd0);
    #2 reset = 1'b1;
    step();
    bus.out_ready = 1'b1;

    // back-to-back addi x1..x3, one issue per cycle
    b2b[0] = mk(32'h8000_0000, 32'h0010_0093, 4'd7, 5'd0, 5'd0, 5'd1, 1'b1, 32'h0000_0001, 1'b0);
    b2b[1] = mk(32'h8000_0004, 32'hFFC0_0113, 4'd7, 5'd0, 5'd0, 5'd2, 1'b1, 32'hFFFF_FFFC, 1'b0);
    b2b[2] = mk(32'h8000_0008, 32'h7FF0_0193, 4'd7, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0000_07FF, 1'b0);
    b2b_busy[0] = 32'h0; b2b_busy[1] = 32'h2; b2b_busy[2] = 32'h6;
    for (int i = 0; i < 3; i++) begin
      send(b2b[i]);
      check("b2b_busy", dut.busy, b2b_busy[i]);
    end
    idle();
    step();
    check("b2b_busy_final", dut.busy, 32'hE);
    for (int r = 1; r <= 3; r++) writeback(5'(r));
    check("wb_clear_busy", dut.busy, 32'h0);

    // RAW stall released by same-cycle writeback bypass
    send(mk(32'h8000_0100, 32'h0010_0293, 4'd7, 5'd0, 5'd0, 5'd5, 1'b1, 32'h1, 1'b0));
    send(mk(32'h8000_0104, 32'h0052_8333, 4'd8, 5'd5, 5'd5, 5'd6, 1'b1, 32'h0, 1'b0));
    idle();
    @(negedge clock);
    check("raw_out_valid", 32'(bus.out_valid), 32'd0);
    check("raw_in_ready",  32'(bus.in_ready),  32'd0);
    check("raw_busy",      dut.busy,           32'h20);
    step();
    @(negedge clock);
    check("raw_still_stalled", 32'(bus.out_valid), 32'd0);
    step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    @(negedge clock);
    check("raw_bypass_valid", 32'(bus.out_valid), 32'd1);
    step();
    bus.wb_valid = 1'b0;
    check("raw_busy_after", dut.busy, 32'h40);

    // flush of a held beq while fetch still offers
    bus.out_ready = 1'b0;
    drive(32'h8000_0010, 32'h0020_8463);
    idle();
    @(negedge clock);
    check("beq_valid", 32'(bus.out_valid), 32'd1);
    check("beq_pc",    bus.out_pc,         32'h8000_0010);
    check("beq_opc",   32'(bus.out_opc),   32'd4);
    check("beq_imm",   bus.out_imm,        32'd8);
    check("beq_rs1",   32'(bus.out_rs1),   32'd1);
    check("beq_rs2",   32'(bus.out_rs2),   32'd2);
    check("beq_rd",    32'(bus.out_rd),    32'd0);
    step();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h8000_0014;
    bus.in_inst  = 32'h0010_0093;
    @(negedge clock);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("post_flush_hold",     32'(dut.hold_valid), 32'd0);
    check("post_flush_in_ready", 32'(bus.in_ready),   32'd1);
    check("post_flush_busy",     dut.busy,            32'h40);
    // flush with an empty hold also blocks capture
    step();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("flush_blocks_capture", 32'(dut.hold_valid), 32'd0);
    step();
    writeback(5'd6);

    // backpressure on a held lw x7,8(x2)
    send(mk(32'h8000_0200, 32'h0081_2383, 4'd5, 5'd2, 5'd0, 5'd7, 1'b1, 32'd8, 1'b0));
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_valid",    32'(bus.out_valid), 32'd1);
      check("bp_pc",       bus.out_pc,         32'h8000_0200);
      check("bp_inst",     bus.out_inst,       32'h0081_2383);
      check("bp_in_ready", 32'(bus.in_ready),  32'd0);
      check("bp_imm",      bus.out_imm,        32'd8);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    step();
    check("bp_busy", dut.busy, 32'h80);
    writeback(5'd7);

    // U/J/S formats and illegal encodings, back to back
    mix[0] = mk(32'h8000_0300, 32'hABCD_E437, 4'd0,  5'd0, 5'd0, 5'd8, 1'b1, 32'hABCD_E000, 1'b0);
    mix[1] = mk(32'h8000_0304, 32'h0100_04EF, 4'd2,  5'd0, 5'd0, 5'd9, 1'b1, 32'h0000_0010, 1'b0);
    mix[2] = mk(32'h8000_0308, 32'hFFDF_F06F, 4'd2,  5'd0, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    mix[3] = mk(32'h8000_030C, 32'hFE30_AA23, 4'd6,  5'd1, 5'd3, 5'd0, 1'b0, 32'hFFFF_FFF4, 1'b0);
    mix[4] = mk(32'h8000_0310, 32'h0000_0000, 4'd15, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1);
    mix[5] = mk(32'h8000_0314, 32'hFFFF_FFFF, 4'd15, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) send(mix[i]);
    idle();
    step();
    check("mix_busy", dut.busy, 32'h0000_0300);
    writeback(5'd8);
    writeback(5'd9);

    // asynchronous reset in the middle of a RAW stall
    send(mk(32'h8000_0400, 32'h0010_0293, 4'd7, 5'd0, 5'd0, 5'd5, 1'b1, 32'h1, 1'b0));
    drive(32'h8000_0404, 32'h0052_8333);
    idle();
    @(negedge clock);
    check("pre_rst_stall",    32'(bus.out_valid), 32'd0);
    check("pre_rst_busy",     dut.busy,           32'h20);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid",    32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready),  32'd1);
    check("async_rst_busy",     dut.busy,           32'd0);
    check("async_rst_pc",       bus.out_pc,         TB_RESET_PC);
    #1 reset = 1'b1;
    step();
    send(mk(32'h8000_0500, 32'h0052_8333, 4'd8, 5'd5, 5'd5, 5'd6, 1'b1, 32'h0, 1'b0));
    idle();
    @(negedge clock);
    check("post_rst_no_hazard", 32'(bus.out_valid), 32'd1);
    step();
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
